// File: rtl/wave_display.sv
// Scope trace renderer: 3-cycle pixel pipeline reading one RAM bank per frame; no backpressure, follows the scan.
// WAVE_DISPLAY_INTERP_EN draws vertical segments between consecutive samples; otherwise single-dot trace.
module wave_display #(
  parameter logic [10:0] X_START   = 11'd256,
  parameter logic [23:0] TRACE_RGB = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);

  typedef enum logic {ST_IDLE = 1'b0, ST_DRAW = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        disp_bank_q, disp_bank_d;
  logic        idle_q, idle_d;
  logic [8:0]  read_address_q, read_address_d;
  logic        s1_vld_q, s1_vld_d;
  logic        s1_win_q, s1_win_d;
  logic [7:0]  s1_row_q, s1_row_d;
  logic        s2_vld_q, s2_vld_d;
  logic        s2_win_q, s2_win_d;
  logic [7:0]  s2_row_q, s2_row_d;
  logic        valid_pixel_q, valid_pixel_d;
  logic [23:0] rgb_q, rgb_d;

  logic        in_win;
  logic [7:0]  idx0;
  logic [7:0]  cur_row;
  logic        on_trace;
  logic        unused_y0;

  assign unused_y0 = y[0];

`ifdef WAVE_DISPLAY_INTERP_EN
  logic [7:0] s1_idx_q, s1_idx_d;
  logic [7:0] s2_idx_q, s2_idx_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] last_idx_q, last_idx_d;
  logic [7:0] prev_eff;
  logic [7:0] prev_row;
  logic [7:0] lo_row, hi_row;
`endif

  always_comb begin
    state_d     = state_q;
    disp_bank_d = disp_bank_q;
    case (state_q)
      ST_IDLE: begin
        disp_bank_d = ~read_index;
        if (!y[9]) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (y[9]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  // Stage 0: window decode and RAM address generation.
  always_comb begin
    in_win = !y[9] && ({1'b0, x} >= {1'b0, X_START})
                   && ({1'b0, x} <  ({1'b0, X_START} + 12'd512));
    idx0   = 8'((x - X_START) >> 1);
    read_address_d = in_win ? {disp_bank_q, idx0} : read_address_q;
    s1_vld_d = valid;
    s1_win_d = in_win;
    s1_row_d = y[8:1];
    s2_vld_d = s1_vld_q;
    s2_win_d = s1_win_q;
    s2_row_d = s1_row_q;
  end

  // Stage 2: read_value belongs to the pixel carried in s2_*.
  always_comb begin
    cur_row = 8'd255 - read_value;
`ifdef WAVE_DISPLAY_INTERP_EN
    s1_idx_d   = idx0;
    s2_idx_d   = s1_idx_q;
    // Index 0 starts each row fresh so the previous row's last sample is not joined.
    prev_eff   = (s2_idx_q == 8'd0) ? read_value : prev_q;
    prev_row   = 8'd255 - prev_eff;
    lo_row     = (prev_row < cur_row) ? prev_row : cur_row;
    hi_row     = (prev_row < cur_row) ? cur_row : prev_row;
    on_trace   = (s2_row_q >= lo_row) && (s2_row_q <= hi_row);
    prev_d     = prev_q;
    last_idx_d = last_idx_q;
    if (s2_win_q) begin
      last_idx_d = s2_idx_q;
      if ((s2_idx_q != last_idx_q) || (s2_idx_q == 8'd0)) prev_d = read_value;
    end
`else
    on_trace = (s2_row_q == cur_row);
`endif
    valid_pixel_d = s2_vld_q && s2_win_q;
    rgb_d         = (valid_pixel_d && on_trace) ? TRACE_RGB : 24'h000000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      disp_bank_q    <= 1'b0;
      idle_q         <= 1'b0;
      read_address_q <= 9'd0;
      s1_vld_q       <= 1'b0;
      s1_win_q       <= 1'b0;
      s1_row_q       <= 8'd0;
      s2_vld_q       <= 1'b0;
      s2_win_q       <= 1'b0;
      s2_row_q       <= 8'd0;
      valid_pixel_q  <= 1'b0;
      rgb_q          <= 24'h000000;
`ifdef WAVE_DISPLAY_INTERP_EN
      s1_idx_q       <= 8'd0;
      s2_idx_q       <= 8'd0;
      prev_q         <= 8'd0;
      last_idx_q     <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      disp_bank_q    <= disp_bank_d;
      idle_q         <= idle_d;
      read_address_q <= read_address_d;
      s1_vld_q       <= s1_vld_d;
      s1_win_q       <= s1_win_d;
      s1_row_q       <= s1_row_d;
      s2_vld_q       <= s2_vld_d;
      s2_win_q       <= s2_win_d;
      s2_row_q       <= s2_row_d;
      valid_pixel_q  <= valid_pixel_d;
      rgb_q          <= rgb_d;
`ifdef WAVE_DISPLAY_INTERP_EN
      s1_idx_q       <= s1_idx_d;
      s2_idx_q       <= s2_idx_d;
      prev_q         <= prev_d;
      last_idx_q     <= last_idx_d;
`endif
    end
  end

  assign read_address      = read_address_q;
  assign valid_pixel       = valid_pixel_q;
  assign r                 = rgb_q[23:16];
  assign g                 = rgb_q[15:8];
  assign b                 = rgb_q[7:0];
  assign wave_display_idle = idle_q;

endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display with a 1-cycle-latency sample RAM model.
module tb_wave_display;
  logic        clk;
  logic        reset_n;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  logic [7:0]  mem [0:511];
  int          total;
  int          bad;
  logic        exp_lit;

  wave_display dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .x                 (x),
    .y                 (y),
    .valid             (valid),
    .read_index        (read_index),
    .read_value        (read_value),
    .read_address      (read_address),
    .valid_pixel       (valid_pixel),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .wave_display_idle (wave_display_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) read_value <= mem[read_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one pixel and wait until its registered colour is visible.
  task automatic pix(input logic [10:0] xx, input logic [9:0] yy, input logic vv);
    x = xx; y = yy; valid = vv;
    tick(); tick(); tick();
  endtask

  task automatic sweep(input logic [9:0] yy, input logic lit);
    for (int i = 0; i < 514; i++) begin
      x = (i < 512) ? 11'(256 + i) : 11'd0;
      y = yy; valid = 1'b1;
      tick();
      if (i >= 2) begin
        chk("sweep_vp", {31'd0, valid_pixel}, 32'd1);
        chk("sweep_rgb", {8'd0, r, g, b}, lit ? 32'h00FFFFFF : 32'd0);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'd128;
    reset_n = 1'b0; x = 11'd0; y = 10'd600; valid = 1'b1; read_index = 1'b1;
    repeat (3) tick();
    chk("rst_vp", {31'd0, valid_pixel}, 32'd0);
    chk("rst_rgb", {8'd0, r, g, b}, 32'd0);
    chk("rst_addr", {23'd0, read_address}, 32'd0);
    chk("rst_idle", {31'd0, wave_display_idle}, 32'd0);
    x = 11'd300; y = 10'd0;
    tick();
    chk("rst_addr_scan", {23'd0, read_address}, 32'd0);

    y = 10'd600; reset_n = 1'b1;
    tick();
    chk("idle_rise", {31'd0, wave_display_idle}, 32'd1);
    y = 10'd0; x = 11'd256;
    tick();
    chk("idle_fall", {31'd0, wave_display_idle}, 32'd0);
    chk("addr_x256", {23'd0, read_address}, 32'h000);
    x = 11'd302;
    tick();
    chk("addr_x302", {23'd0, read_address}, 32'h017);
    read_index = 1'b0; x = 11'd300;
    tick();
    chk("addr_bank_frozen", {23'd0, read_address}, 32'h016);

    y = 10'd600;
    tick(); tick();
    y = 10'd0; x = 11'd256;
    tick();
    chk("addr_bank1", {23'd0, read_address}, 32'h100);
    read_index = 1'b1; x = 11'd258;
    tick();
    chk("addr_bank1_frozen", {23'd0, read_address}, 32'h101);
    y = 10'd600;
    tick(); tick();
    chk("idle_again", {31'd0, wave_display_idle}, 32'd1);

    sweep(10'd254, 1'b1);
    sweep(10'd255, 1'b1);
    sweep(10'd252, 1'b0);

    pix(11'd255, 10'd10, 1'b1);
    chk("edge_255_vp", {31'd0, valid_pixel}, 32'd0);
    chk("edge_255_rgb", {8'd0, r, g, b}, 32'd0);
    pix(11'd768, 10'd10, 1'b1);
    chk("edge_768_vp", {31'd0, valid_pixel}, 32'd0);
    chk("edge_768_rgb", {8'd0, r, g, b}, 32'd0);
    pix(11'd256, 10'd10, 1'b1);
    chk("edge_256_vp", {31'd0, valid_pixel}, 32'd1);
    chk("edge_256_rgb", {8'd0, r, g, b}, 32'd0);
    pix(11'd767, 10'd10, 1'b1);
    chk("edge_767_vp", {31'd0, valid_pixel}, 32'd1);

    x = 11'd400; y = 10'd254; valid = 1'b0;
    tick();
    chk("novalid_addr", {23'd0, read_address}, 32'h048);
    tick(); tick();
    chk("novalid_vp", {31'd0, valid_pixel}, 32'd0);
    chk("novalid_rgb", {8'd0, r, g, b}, 32'd0);
    valid = 1'b1;

    mem[4] = 8'd0; mem[5] = 8'd255;
    for (int k = 0; k < 256; k++) begin
      y = 10'(2 * k); valid = 1'b1;
      x = 11'd262; tick();
      x = 11'd264; tick();
      x = 11'd265; tick();
      x = 11'd266; tick();
      x = 11'd0;   tick(); tick();
`ifdef WAVE_DISPLAY_INTERP_EN
      exp_lit = 1'b1;
`else
      exp_lit = (k == 0);
`endif
      chk("seg_vp", {31'd0, valid_pixel}, 32'd1);
      chk("seg_rgb", {8'd0, r, g, b}, exp_lit ? 32'h00FFFFFF : 32'd0);
    end
    mem[4] = 8'd128; mem[5] = 8'd128;

    for (int i = 256; i <= 500; i++) begin
      x = 11'(i); y = 10'd254; valid = 1'b1;
      tick();
    end
    chk("pre_rst_rgb", {8'd0, r, g, b}, 32'h00FFFFFF);
    reset_n = 1'b0;
    #1;
    chk("midrst_vp", {31'd0, valid_pixel}, 32'd0);
    chk("midrst_rgb", {8'd0, r, g, b}, 32'd0);
    chk("midrst_addr", {23'd0, read_address}, 32'd0);
    chk("midrst_idle", {31'd0, wave_display_idle}, 32'd0);
    tick(); tick();
    y = 10'd600; read_index = 1'b1; reset_n = 1'b1;
    tick(); tick();
    pix(11'd256, 10'd400, 1'b1);
    chk("post_rst_vp", {31'd0, valid_pixel}, 32'd1);
    chk("post_rst_noseg", {8'd0, r, g, b}, 32'd0);
    pix(11'd256, 10'd254, 1'b1);
    chk("post_rst_lit", {8'd0, r, g, b}, 32'h00FFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
